// File: rtl/lz_code_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lzdec_pkg
//  Purpose  : Shared types, constants and the code-to-mask decode function for
//             the leading-one code decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package lzdec_pkg;

  localparam int         WIDTH_DEFAULT = 16;
  localparam int         LZDEC_MAX_W   = 128;
  localparam logic [7:0] NONE_CODE     = 8'hF0;

  // Mask field is sized for the widest legal configuration; narrower
  // instances only ever see zeros above their own WIDTH.
  typedef struct packed {
    logic [LZDEC_MAX_W-1:0] mask;
    logic                   none;
    logic                   err;
  } lzdec_entry_t;

  // Turns one index code into its mask plus the none/illegal flags.
  // thermo selects a [code:0] fill pattern instead of a single bit.
  function automatic lzdec_entry_t decode_code(input logic [7:0] code,
                                               input logic       thermo,
                                               input int         width);
    lzdec_entry_t e;
    logic [7:0]   shamt;
    e     = '0;
    shamt = code + 8'd1;
    if (int'({24'd0, code}) < width) begin
      if (thermo) begin
        // A shift by 128 clears every bit, so the inversion yields all ones.
        e.mask = ~({LZDEC_MAX_W{1'b1}} << shamt);
      end else begin
        e.mask = {{(LZDEC_MAX_W-1){1'b0}}, 1'b1} << code;
      end
    end else if (code == NONE_CODE) begin
      e.none = 1'b1;
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lz_code_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : lz_code_decoder_if
//  Purpose  : Code-in / mask-out stream bundle for lz_code_decoder.
//             LZDEC_THERMO_EN adds the thermo select signal.
//  Revision : 1.0 - initial release
// ============================================================================
interface lz_code_decoder_if
  import lzdec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_code;
  logic             acc_en;
  logic             acc_clr;
`ifdef LZDEC_THERMO_EN
  logic             thermo;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mask;
  logic             out_none;
  logic             out_err;

`ifdef LZDEC_THERMO_EN
  modport master (output in_valid, in_code, acc_en, acc_clr, thermo, out_ready,
                  input  in_ready, out_valid, out_mask, out_none, out_err);
  modport slave  (input  in_valid, in_code, acc_en, acc_clr, thermo, out_ready,
                  output in_ready, out_valid, out_mask, out_none, out_err);
`else
  modport master (output in_valid, in_code, acc_en, acc_clr, out_ready,
                  input  in_ready, out_valid, out_mask, out_none, out_err);
  modport slave  (input  in_valid, in_code, acc_en, acc_clr, out_ready,
                  output in_ready, out_valid, out_mask, out_none, out_err);
`endif

endinterface
`default_nettype wire

// File: rtl/lz_code_decoder_fifo2.sv
`default_nettype none
// ============================================================================
//  Module   : lzdec_fifo2
//  Purpose  : Two-entry synchronous FIFO with valid/ready on both sides.
//             Head entry is a register that feeds the outputs directly and is
//             zero whenever the FIFO is empty.
//  Revision : 1.0 - initial release
// ============================================================================
module lzdec_fifo2
  import lzdec_pkg::*;
#(
  parameter type T = lzdec_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic [1:0] r_count;
  logic       r_ready;
  T           r_head;
  T           r_tail;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_next;

  assign w_push    = in_valid && r_ready;
  assign w_pop     = out_valid && out_ready;
  assign in_ready  = r_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 2'd1;
    end
  end

  // Storage, occupancy and a registered ready so out_ready never reaches in_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_ready <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_count_next;
      r_ready <= (w_count_next != 2'd2);
      case (r_count)
        2'd0: begin
          if (w_push) r_head <= in_data;
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= in_data;
          end else if (w_push) begin
            r_tail <= in_data;
          end else if (w_pop) begin
            r_head <= '0;
          end
        end
        default: begin
          // Full: ready is low, so only a pop can happen here.
          if (w_pop) begin
            r_head <= r_tail;
            r_tail <= '0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lz_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : lz_code_decoder
//  Purpose  : Inverse of the leading-one priority encoder. Decodes 8-bit index
//             codes back into WIDTH-bit masks with optional OR-accumulation,
//             buffered through a two-entry output FIFO.
//             Optional macro LZDEC_THERMO_EN adds thermometer decoding.
//  Revision : 1.0 - initial release
// ============================================================================
module lz_code_decoder
  import lzdec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  lz_code_decoder_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] mask;
    logic             none;
    logic             err;
  } entry_t;

  lzdec_entry_t     w_dec_full;
  entry_t           w_dec;
  entry_t           w_push;
  entry_t           w_head;
  logic             w_hi_set;
  logic             w_thermo;
  logic             w_accept;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] r_acc;

`ifdef LZDEC_THERMO_EN
  assign w_thermo = bus.thermo;
`else
  assign w_thermo = 1'b0;
`endif

  assign w_dec_full = decode_code(bus.in_code, w_thermo, WIDTH);

  // Any decoded bit above WIDTH would be an out-of-range index; treat as illegal.
  if (WIDTH < LZDEC_MAX_W) begin : g_hi_check
    assign w_hi_set = |w_dec_full.mask[LZDEC_MAX_W-1:WIDTH];
  end else begin : g_no_hi_check
    assign w_hi_set = 1'b0;
  end

  assign w_dec.mask = w_dec_full.mask[WIDTH-1:0];
  assign w_dec.none = w_dec_full.none;
  assign w_dec.err  = w_dec_full.err | w_hi_set;

  assign w_accept = bus.in_valid && w_in_ready;

  // Pushed entry and next accumulator: clear applies first, then the new bits.
  always_comb begin
    w_acc_base  = bus.acc_clr ? '0 : r_acc;
    w_acc_next  = w_acc_base;
    w_push      = '0;
    w_push.none = w_dec.none;
    w_push.err  = w_dec.err;
    if (w_dec.err) begin
      w_push.mask = '0;
    end else if (bus.acc_en) begin
      w_push.mask = w_acc_base | w_dec.mask;
    end else begin
      w_push.mask = w_dec.mask;
    end
    if (w_accept && bus.acc_en && !w_dec.err) begin
      w_acc_next = w_acc_base | w_dec.mask;
    end
  end

  // Accumulator register; clear acts every cycle regardless of handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

  lzdec_fifo2 #(
    .T (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_push),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (w_head)
  );

  assign bus.in_ready = w_in_ready;
  assign bus.out_mask = w_head.mask;
  assign bus.out_none = w_head.none;
  assign bus.out_err  = w_head.err;

endmodule
`default_nettype wire

// File: tb/tb_lz_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lz_code_decoder
//  Purpose  : Scoreboard bench for lz_code_decoder with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lz_code_decoder;
  import lzdec_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lz_code_decoder_if #(.WIDTH(W)) bus ();

  lz_code_decoder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] mask;
    bit           none;
    bit           err;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          or_mode = 2;
  bit          mon_en = 1'b0;
  int unsigned acc_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: one clock cycle of the decoder as seen from the input side.
  task automatic model_cycle(input bit valid, input int code, input bit en,
                             input bit clr, input bit th, output bit accepted);
    int unsigned base, pat;
    exp_t        e;
    bit          legal;
    accepted = 1'b0;
    base = clr ? 0 : acc_m;
    if (valid && bus.in_ready === 1'b1) begin
      accepted = 1'b1;
      legal  = (code < W);
      e.none = (code == 240);
      e.err  = !legal && !e.none;
      pat    = legal ? (th ? (2 ** (code + 1)) - 1 : 2 ** code) : 0;
      if (e.err)   e.mask = '0;
      else if (en) e.mask = W'(base | pat);
      else         e.mask = W'(pat);
      sbq.push_back(e);
      if (en && legal) base = base | pat;
    end
    acc_m = base;
  endtask

  task automatic send(input int code, input bit en, input bit clr, input bit th);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 64) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_code  = 8'(code);
      bus.acc_en   = en;
      bus.acc_clr  = clr;
`ifdef LZDEC_THERMO_EN
      bus.thermo   = th;
`endif
      @(negedge clk);
      model_cycle(1'b1, code, en, clr, th, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout code=%0d accepted=0 required=1", code);
    end
  endtask

  task automatic idle(input bit clr);
    bit acc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.acc_clr  = clr;
    @(negedge clk);
    model_cycle(1'b0, 0, 1'b0, clr, 1'b0, acc);
  endtask

  // Consumer ready pattern: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom % 2);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    exp_t         e;
    bit           hold_p = 1'b0;
    logic [W-1:0] pm;
    logic         pn, pe;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (hold_p) begin
          checks++;
          if (!(bus.out_valid === 1'b1 && bus.out_mask === pm &&
                bus.out_none === pn && bus.out_err === pe)) begin
            errors++;
            $display("FAIL hold_stable valid=%b mask=%h none=%b err=%b required mask=%h none=%b err=%b",
                     bus.out_valid, bus.out_mask, bus.out_none, bus.out_err, pm, pn, pe);
          end
        end
        if (bus.out_valid === 1'b1) begin
          if (bus.out_ready === 1'b1) begin
            hold_p = 1'b0;
            checks++;
            if (sbq.size() == 0) begin
              errors++;
              $display("FAIL unexpected_output mask=%h required none", bus.out_mask);
            end else begin
              e = sbq.pop_front();
              if (bus.out_mask !== e.mask || bus.out_none !== e.none || bus.out_err !== e.err) begin
                errors++;
                $display("FAIL output mask=%h none=%b err=%b required mask=%h none=%b err=%b",
                         bus.out_mask, bus.out_none, bus.out_err, e.mask, e.none, e.err);
              end
            end
          end else begin
            hold_p = 1'b1;
            pm = bus.out_mask;
            pn = bus.out_none;
            pe = bus.out_err;
          end
        end else begin
          hold_p = 1'b0;
          checks++;
          if (bus.out_mask !== '0 || bus.out_none !== 1'b0 || bus.out_err !== 1'b0) begin
            errors++;
            $display("FAIL empty_outputs mask=%h none=%b err=%b required all zero",
                     bus.out_mask, bus.out_none, bus.out_err);
          end
        end
      end else begin
        hold_p = 1'b0;
      end
    end
  end

  initial begin
    int code, r;
    bit th;
    bus.in_valid = 1'b1;
    bus.in_code  = 8'd5;
    bus.acc_en   = 1'b0;
    bus.acc_clr  = 1'b0;
`ifdef LZDEC_THERMO_EN
    bus.thermo   = 1'b0;
`endif

    // Reset held two cycles with in_valid asserted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_mask", 32'(bus.out_mask), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    acc_m  = 0;
    mon_en = 1'b1;
    or_mode = 0;

    // First code after reset appears one cycle after acceptance.
    send(5, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    chk("latency_mask", 32'(bus.out_mask), 32'h0020);

    // Back-to-back mix of legal, none and illegal codes.
    send(0, 1'b0, 1'b0, 1'b0);
    send(15, 1'b0, 1'b0, 1'b0);
    send(240, 1'b0, 1'b0, 1'b0);
    send(16, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Backpressure: two entries fill the FIFO, the third stalls.
    or_mode = 2;
    idle(1'b0);
    idle(1'b0);
    send(1, 1'b0, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0, 1'b0);
    begin
      bit acc;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_code  = 8'd3;
      bus.acc_en   = 1'b0;
      bus.acc_clr  = 1'b0;
      @(negedge clk);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      model_cycle(1'b1, 3, 1'b0, 1'b0, 1'b0, acc);
    end
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("stalled_in_ready", 32'(bus.in_ready), 32'd0);
    end
    or_mode = 0;
    send(3, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Accumulation, including clear together with an accept.
    idle(1'b1);
    send(0, 1'b1, 1'b0, 1'b0);
    send(4, 1'b1, 1'b0, 1'b0);
    send(240, 1'b1, 1'b0, 1'b0);
    send(15, 1'b1, 1'b0, 1'b0);
    send(2, 1'b1, 1'b1, 1'b0);
    idle(1'b0);

    // Illegal code leaves the accumulator untouched.
    idle(1'b1);
    send(0, 1'b1, 1'b0, 1'b0);
    send(1, 1'b1, 1'b0, 1'b0);
    send(32, 1'b1, 1'b0, 1'b0);
    send(4, 1'b1, 1'b0, 1'b0);
    idle(1'b0);

`ifdef LZDEC_THERMO_EN
    send(3, 1'b0, 1'b0, 1'b1);
    send(15, 1'b0, 1'b0, 1'b1);
    send(240, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
`endif

    // Reset mid-operation discards buffered entries and the accumulator.
    or_mode = 2;
    send(7, 1'b1, 1'b0, 1'b0);
    send(8, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midreset_out_mask", 32'(bus.out_mask), 32'd0);
    sbq.delete();
    acc_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    or_mode = 0;
    mon_en = 1'b1;
    send(9, 1'b1, 1'b0, 1'b0);
    idle(1'b0);

    // Randomized traffic with random consumer stalls.
    or_mode = 1;
    repeat (400) begin
      if ($urandom % 4 == 0) begin
        idle(($urandom % 8) == 0);
      end else begin
        r = int'($urandom % 10);
        if (r < 7)       code = int'($urandom % 16);
        else if (r == 7) code = 240;
        else begin
          code = int'($urandom_range(16, 255));
          if (code == 240) code = 241;
        end
`ifdef LZDEC_THERMO_EN
        th = 1'($urandom % 2);
`else
        th = 1'b0;
`endif
        send(code, 1'($urandom % 2), ($urandom % 8) == 0, th);
      end
    end

    // Drain whatever is left and confirm nothing was lost.
    or_mode = 0;
    for (int i = 0; i < 50; i++) begin
      if (sbq.size() == 0) break;
      idle(1'b0);
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lz_code_decoder.md
Name: lz_code_decoder

Overview:
- Inverse of the leading-one priority encoder. Consumes 8-bit index codes in the encoder's output format: 0..WIDTH-1 = bit index, 8'hF0 = "no one found".
- Regenerates the WIDTH-bit one-hot mask, with optional OR-accumulation across codes.
- Streaming block with valid/ready on both sides and a 2-entry output FIFO. Sits between the encoder result path and downstream mask consumers / test readback.

Parameters:
- WIDTH, 16, mask width; power of 2, 2..128; IDX_W = clog2(WIDTH).
- NONE_CODE, 8'hF0, code meaning "no one set"; must be >= WIDTH.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_code valid.
- in_ready  output  1  block can accept; code accepted when in_valid && in_ready.
- in_code  input  8  index code.
- acc_en  input  1  sampled on accept: output is accumulator OR new bit.
- acc_clr  input  1  synchronous accumulator clear; independent of handshake.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes head when out_valid && out_ready.
- out_mask  output  WIDTH  decoded mask of head entry.
- out_none  output  1  head entry came from NONE_CODE.
- out_err  output  1  head entry came from an illegal code.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Clock port clk, reset port rst_n.
- Reset (rst_n=0 at a clock edge):
  - FIFO count=0, acc=0, out_valid=0, in_ready=0 during reset, out_mask/out_none/out_err=0.
  - Reset mid-operation discards all FIFO entries and acc.
- Decode, combinational on in_code:
  - code < WIDTH: onehot = 1<<code[IDX_W-1:0]; none=0, err=0.
  - code == NONE_CODE: onehot = 0; none=1, err=0.
  - Any other code: onehot = 0; none=0, err=1.
  - Illegal codes are still accepted and pushed (no stall) and never modify acc.
- Accumulator, on a clock edge:
  - acc_base = acc_clr ? 0 : acc.
  - On accept with acc_en=1 and legal code: acc <= acc_base | onehot; pushed mask = acc_base | onehot.
  - On accept with acc_en=0: pushed mask = onehot; acc <= acc_base.
  - Clear and accept in the same cycle: clear first, then OR the new bit.
  - NONE_CODE with acc_en=1 pushes acc_base (mask unchanged), out_none=1.
- FIFO: 2 entries of {mask, none, err}; head drives outputs directly from registers.
  - in_ready = (count < 2), registered-derived with no combinational path from out_ready.
  - count 0: accept -> out_valid next cycle; latency is 1 cycle.
  - count 1: simultaneous push and pop allowed; count stays 1 and the new entry becomes head.
  - count 2: in_ready=0; a pop frees a slot for the next cycle.
  - Entries emerge in acceptance order; no loss or duplication.
  - Outputs hold stable while out_valid && !out_ready.
  - Outputs are 0 when count=0.

Optional Feature:
- Macro LZDEC_THERMO_EN.
- Defined:
  - Adds input port thermo (1 bit), sampled on accept.
  - thermo=1 with a legal code: decoded pattern = bits [code:0] all set (e.g. code 3 -> 16'h000F) instead of one-hot.
  - Accumulation ORs the thermometer pattern.
  - NONE_CODE and illegal-code handling are unchanged.
- Undefined: no thermo port; one-hot only.

Decomposition:
- Package lzdec_pkg:
  - WIDTH_DEFAULT=16, NONE_CODE=8'hF0.
  - Typedef lzdec_entry_t = {mask, none, err}.
  - Function decode_code(code, thermo) returning lzdec_entry_t.
- Sub-module lzdec_fifo2: 2-entry synchronous FIFO of lzdec_entry_t, with valid/ready on both sides, count, and the same clk/rst_n.
- Top lz_code_decoder holds decode logic, accumulator and handshake glue.

Test Plan:
- Reset: hold rst_n=0 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_mask=0; release, send code 5 -> next cycle out_mask=16'h0020, none=0, err=0.
- Codes 0,15,8'hF0,8'h10 back-to-back with out_ready=1 -> masks 16'h0001, 16'h8000, 16'h0000 (none=1), 16'h0000 (err=1), one per cycle, in order.
- Backpressure: out_ready=0, push codes 1,2,3 -> in_ready drops after 2 accepts, code 3 stalls; raise out_ready -> 16'h0002, 16'h0004, 16'h0008 in order.
- Accumulate: acc_en=1, codes 0,4,8'hF0,15 -> 16'h0001, 16'h0011, 16'h0011 (none=1), 16'h8011; then acc_clr=1 with code 2 same cycle -> 16'h0004.
- Illegal 8'h20 with acc_en=1 after acc=16'h0003 -> err=1, mask=16'h0000; next legal code 4 -> 16'h0013.
- LZDEC_THERMO_EN build: thermo=1, code 3 -> 16'h000F; code 15 -> 16'hFFFF; NONE_CODE -> 16'h0000, none=1.
